// File: rtl/cpu_controller.sv
// Multi-cycle control unit for the 8-bit accumulator datapath: sequences
// fetch/decode/execute and owns the memory read/write handshake.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op_code,
  input  logic       mem_ready,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_acii,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       source_ac,
  output logic [1:0] pass_add,
  output logic       sel_acii,
  output logic       sel_ir,
  output logic       sel_zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] StRst    = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [2:0] OpLda  = 3'b000;
  localparam logic [2:0] OpSta  = 3'b001;
  localparam logic [2:0] OpAddi = 3'b010;
  localparam logic [2:0] OpAddx = 3'b011;
  localparam logic [2:0] OpMvx  = 3'b100;
  localparam logic [2:0] OpJpx  = 3'b101;
  localparam logic [2:0] OpHlt  = 3'b111;

  logic [2:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRst;
    else     state_q <= state_d;
  end

  assign state_dbg = state_q;

  // Outputs follow the state; only ld_ir, ld_ac and the FETCH/MEM exits look at mem_ready.
  always_comb begin
    state_d   = StRst;
    ir_on_adr = 1'b0;
    pc_on_adr = 1'b0;
    ld_ir     = 1'b0;
    ld_ac     = 1'b0;
    ld_acii   = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    clr_pc    = 1'b0;
    source_ac = 1'b0;
    pass_add  = 2'b00;
    sel_acii  = 1'b0;
    sel_ir    = 1'b0;
    sel_zero  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted    = 1'b0;

    case (state_q)
      StRst: begin
        clr_pc  = 1'b1;
        state_d = StFetch;
      end
      StFetch: begin
        pc_on_adr = 1'b1;
        mem_rd    = 1'b1;
        ld_ir     = mem_ready;
        state_d   = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        inc_pc = 1'b1;
        if (op_code == OpLda || op_code == OpSta) state_d = StMem;
        else if (op_code == OpHlt)                state_d = StHalt;
        else                                      state_d = StExec;
      end
      StMem: begin
        ir_on_adr = 1'b1;
        if (op_code == OpLda) begin
          mem_rd = 1'b1;
          ld_ac  = mem_ready;
        end else if (op_code == OpSta) begin
          // Pass AC through the ALU with a zero operand so it lands on the data bus.
          mem_wr   = 1'b1;
          sel_zero = 1'b1;
        end
        state_d = mem_ready ? StFetch : StMem;
      end
      StExec: begin
        state_d = StFetch;
        case (op_code)
          OpAddi: begin
            sel_ir    = 1'b1;
            pass_add  = 2'b01;
            source_ac = 1'b1;
            ld_ac     = 1'b1;
          end
          OpAddx: begin
            sel_acii  = 1'b1;
            pass_add  = 2'b01;
            source_ac = 1'b1;
            ld_ac     = 1'b1;
          end
          OpMvx: begin
            sel_zero = 1'b1;
            ld_acii  = 1'b1;
          end
          OpJpx:   ld_pc = 1'b1;
          default: ;
        endcase
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StRst;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: walks each instruction class cycle by
// cycle and compares the state and the packed control word against constants.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op_code;
  logic       mem_ready;
  logic       ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_acii, ld_pc, inc_pc, clr_pc;
  logic       source_ac, sel_acii, sel_ir, sel_zero, mem_rd, mem_wr, halted;
  logic [1:0] pass_add;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Control word bit masks, in the order of the ctrlObs concatenation below.
  localparam logic [16:0] IRADR  = 17'h1 << 16;
  localparam logic [16:0] PCADR  = 17'h1 << 15;
  localparam logic [16:0] LDIR   = 17'h1 << 14;
  localparam logic [16:0] LDAC   = 17'h1 << 13;
  localparam logic [16:0] LDACII = 17'h1 << 12;
  localparam logic [16:0] LDPC   = 17'h1 << 11;
  localparam logic [16:0] INCPC  = 17'h1 << 10;
  localparam logic [16:0] CLRPC  = 17'h1 << 9;
  localparam logic [16:0] SRCAC  = 17'h1 << 8;
  localparam logic [16:0] PAADD  = 17'h1 << 6;
  localparam logic [16:0] SELAC2 = 17'h1 << 5;
  localparam logic [16:0] SELIR  = 17'h1 << 4;
  localparam logic [16:0] SELZ   = 17'h1 << 3;
  localparam logic [16:0] MRD    = 17'h1 << 2;
  localparam logic [16:0] MWR    = 17'h1 << 1;
  localparam logic [16:0] HALTB  = 17'h1;

  localparam logic [16:0] E_RST     = CLRPC;
  localparam logic [16:0] E_FETCHW  = PCADR | MRD;
  localparam logic [16:0] E_FETCH   = PCADR | MRD | LDIR;
  localparam logic [16:0] E_DECODE  = INCPC;
  localparam logic [16:0] E_LDAW    = IRADR | MRD;
  localparam logic [16:0] E_LDA     = IRADR | MRD | LDAC;
  localparam logic [16:0] E_STA     = IRADR | MWR | SELZ;
  localparam logic [16:0] E_ADDI    = SELIR | PAADD | SRCAC | LDAC;
  localparam logic [16:0] E_ADDX    = SELAC2 | PAADD | SRCAC | LDAC;
  localparam logic [16:0] E_MVX     = SELZ | LDACII;
  localparam logic [16:0] E_JPX     = LDPC;
  localparam logic [16:0] E_NONE    = 17'h0;
  localparam logic [16:0] E_HALT    = HALTB;

  logic [16:0] ctrlObs;
  assign ctrlObs = {ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_acii, ld_pc, inc_pc, clr_pc,
                    source_ac, pass_add, sel_acii, sel_ir, sel_zero, mem_rd, mem_wr, halted};

  cpu_controller dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_acii(ld_acii), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc),
    .source_ac(source_ac), .pass_add(pass_add), .sel_acii(sel_acii), .sel_ir(sel_ir),
    .sel_zero(sel_zero), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare state and control word.
  task automatic applyStimulus(input string tag, input logic [2:0] expState, input logic [16:0] expCtrl);
    #1;
    checkOutput({tag, ".state"}, 32'(state_dbg), 32'(expState));
    checkOutput({tag, ".ctrl"}, 32'(ctrlObs), 32'(expCtrl));
  endtask

  // One instruction with zero-wait memory: FETCH, DECODE, then EXEC or MEM.
  task automatic runInstr(input string tag, input logic [2:0] op, input logic [2:0] thirdState,
                          input logic [16:0] thirdCtrl);
    mem_ready = 1'b1;
    applyStimulus({tag, ".fetch"}, 3'd1, E_FETCH);
    tick();
    op_code = op;
    applyStimulus({tag, ".decode"}, 3'd2, E_DECODE);
    tick();
    applyStimulus({tag, ".exec"}, thirdState, thirdCtrl);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    op_code = 3'b000;
    mem_ready = 1'b0;

    // Reset for two cycles, then ADDI from address 0.
    tick();
    tick();
    rst = 1'b0;
    applyStimulus("rst", 3'd0, E_RST);
    tick();
    runInstr("addi", 3'b010, 3'd3, E_ADDI);
    applyStimulus("addi.back", 3'd1, E_FETCH);

    // FETCH with three wait cycles, then LDA with two wait cycles in MEM.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("fetchwait", 3'd1, E_FETCHW);
      tick();
    end
    mem_ready = 1'b1;
    applyStimulus("fetchrdy", 3'd1, E_FETCH);
    tick();
    op_code = 3'b000;
    applyStimulus("lda.decode", 3'd2, E_DECODE);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus("ldawait", 3'd4, E_LDAW);
      tick();
    end
    mem_ready = 1'b1;
    applyStimulus("lda.rdy", 3'd4, E_LDA);
    tick();

    runInstr("sta", 3'b001, 3'd4, E_STA);
    runInstr("mvx", 3'b100, 3'd3, E_MVX);
    runInstr("addx", 3'b011, 3'd3, E_ADDX);
    runInstr("jpx", 3'b101, 3'd3, E_JPX);
    runInstr("nop", 3'b110, 3'd3, E_NONE);

    // HALT ignores mem_ready and holds until reset.
    runInstr("hlt", 3'b111, 3'd5, E_HALT);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      applyStimulus("halt", 3'd5, E_HALT);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus("halt.rst", 3'd0, E_RST);
    tick();
    mem_ready = 1'b1;
    applyStimulus("halt.fetch", 3'd1, E_FETCH);
    tick();

    // Reset asserted in the middle of an LDA wait.
    op_code = 3'b000;
    applyStimulus("mid.decode", 3'd2, E_DECODE);
    tick();
    mem_ready = 1'b0;
    applyStimulus("mid.mem", 3'd4, E_LDAW);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus("mid.rst", 3'd0, E_RST);
    tick();
    applyStimulus("mid.fetch", 3'd1, E_FETCHW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control unit for the 8-bit accumulator datapath (AC, ACII, IR, 6-bit PC, ALU). Sequences fetch, decode and execute, and drives every datapath control line from a state machine keyed on the 3-bit `op_code`. Owns the memory read/write handshake on the shared address and data buses. Sits between the top-level memory interface and the datapath, and is the only driver of datapath control inputs.

## Interface
- Parameters: none. Opcode map, states and widths are fixed.
- Ports (name, direction, width, meaning):
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_code` in 3: `IR[7:5]` from the datapath.
- `mem_ready` in 1: memory completes the current read or write in this cycle.
- `ir_on_adr`, `pc_on_adr` out 1 each: address bus source select.
- `ld_ir`, `ld_ac`, `ld_acii`, `ld_pc`, `inc_pc`, `clr_pc` out 1 each: register strobes.
- `source_ac` out 1: AC input select. 0 selects `data_bus_in`; 1 selects the ALU result.
- `pass_add` out 2: ALU function. 00 passes A; 01 computes A + operand2. 10 and 11 are never driven.
- `sel_acii`, `sel_ir`, `sel_zero` out 1 each: operand2 select, one-hot or all zero.
- `mem_rd`, `mem_wr` out 1 each: memory request strobes. Never asserted together.
- `halted` out 1: high while in the HALT state.
- `state_dbg` out 3: current state encoding.

## Operation
- States:
  - RST = 0
  - FETCH = 1
  - DECODE = 2
  - EXEC = 3
  - MEM = 4
  - HALT = 5
  - Codes 6 and 7 are illegal and go to RST on the next clock.
- Default value of every output is 0 unless a state below lists it.
- RST: `clr_pc`=1. Next state is FETCH.
- FETCH: `pc_on_adr`=1, `mem_rd`=1.
  - When `mem_ready`=1: `ld_ir`=1, next state DECODE.
  - Otherwise: stay in FETCH with all strobes held.
- DECODE: `inc_pc`=1.
  - Opcodes 000 and 001 go to MEM.
  - Opcode 111 goes to HALT.
  - All other opcodes go to EXEC.
- MEM: `ir_on_adr`=1.
  - Opcode 000 (LDA, AC <- mem[IR[4:0]]): `mem_rd`=1, `source_ac`=0, `ld_ac`=`mem_ready`.
  - Opcode 001 (STA, mem[IR[4:0]] <- AC): `mem_wr`=1, `pass_add`=00, `sel_zero`=1, so the data bus carries AC.
  - `mem_ready`=1 goes to FETCH; `mem_ready`=0 holds MEM.
- EXEC (always one cycle, then FETCH):
  - 010 ADDI, AC <- AC + IR[4:0]: `sel_ir`, `pass_add`=01, `source_ac`=1, `ld_ac`.
  - 011 ADDX, AC <- AC + ACII: `sel_acii`, `pass_add`=01, `source_ac`=1, `ld_ac`.
  - 100 MVX, ACII <- AC: `sel_zero`, `pass_add`=00, `ld_acii`.
  - 101 JPX, PC <- ACII[4:0]: `ld_pc`.
  - 110 NOP: no strobes.
- HALT: all strobes 0 and `halted`=1. The only exit is `rst`.
- Arithmetic is 8-bit with wrap-around and no carry output. The controller performs no width checks; PC wrap 63 -> 0 belongs to the datapath.

## Timing
- State and `state_dbg` are registered.
- Outputs are combinational from the state register. The Mealy exceptions are `ld_ir`, `ld_ac` in MEM, and the FETCH/MEM transitions, which also depend on `mem_ready`.
- Reset:
  - `rst` high at a clock edge puts the FSM in RST from the next cycle. This applies from any state, including mid-handshake.
  - `mem_rd`/`mem_wr` drop in the cycle after reset is sampled.
  - In RST every output is 0 except `clr_pc`=1, and `state_dbg`=0.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - ALU, move, jump and NOP instructions: 3 cycles (FETCH, DECODE, EXEC).
  - LDA and STA: 3 cycles (FETCH, DECODE, MEM).
  - Each wait cycle on memory adds 1 cycle.
- Handshake:
  - A request holds stable, with the same address source, until the cycle `mem_ready`=1.
  - `mem_ready` outside FETCH or MEM is ignored.
- The first FETCH after reset reads PC=0.

## Test plan
- Reset and ADDI:
  - Stimulus: assert `rst` for 2 cycles, memory word 0 = 010_00101.
  - Required: one `clr_pc` pulse; FETCH shows `pc_on_adr`, `mem_rd`, `ld_ir`; DECODE shows `inc_pc`; EXEC shows `sel_ir`, `pass_add`=01, `ld_ac`, `source_ac`=1; back in FETCH at cycle 4.
- Wait states:
  - Stimulus: hold `mem_ready`=0 for 3 cycles in FETCH, then an LDA (000_01010) with 2 wait cycles in MEM.
  - Required: `mem_rd` held throughout; `ld_ir` and `ld_ac` pulse exactly once each, in the `mem_ready` cycle; `ir_on_adr`=1 during MEM.
- STA:
  - Stimulus: opcode 001 with `mem_ready`=1.
  - Required: a MEM cycle with `mem_wr`=1, `mem_rd`=0, `sel_zero`=1, `pass_add`=00; no `ld_*` strobe asserted.
- MVX, ADDX, JPX sequence:
  - Required: `ld_acii` in the MVX EXEC; `sel_acii`/`ld_ac` in the ADDX EXEC; `ld_pc` in the JPX EXEC, with `inc_pc` seen only in DECODE.
- HALT:
  - Stimulus: opcode 111, then 10 idle cycles with `mem_ready` toggling.
  - Required: `halted`=1 and no strobe for all 10 cycles; `rst` then returns to RST and FETCH.
- Reset mid-MEM:
  - Stimulus: assert `rst` while in MEM with `mem_ready`=0.
  - Required: the next cycle shows `state_dbg`=0, `mem_rd`=0, `clr_pc`=1.
